// File: rtl/rr_burst_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin burst arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, GRANT)
//   next_ptr()  : advance a requester index by one, wrapping n-1 -> 0
// ----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int next_ptr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. Scans req starting at ptr, moving
// upward and wrapping through index 0, and reports the first set bit.
// Ports:
//   req     in   N      request vector
//   ptr     in   ID_W   index with highest priority
//   pick    out  N      one-hot winner (all zero when nothing requested)
//   pick_id out  ID_W   index of the winner (0 when nothing requested)
//   any     out  1      at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    pick,
    output logic [ID_W-1:0] pick_id,
    output logic            any
);

    localparam logic [ID_W:0] N_W = (ID_W + 1)'(N);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            // ptr + i is always below 2N, so one conditional subtract wraps it
            sum = {1'b0, ptr} + (ID_W + 1)'(i);
            idx = (sum >= N_W) ? ID_W'(sum - N_W) : sum[ID_W-1:0];
            if (!any && req[idx]) begin
                any       = 1'b1;
                pick[idx] = 1'b1;
                pick_id   = idx;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// ----------------------------------------------------------------------------
// rr_burst_arbiter
// Round-robin arbiter sharing one register-bank write port among N
// requesters. One requester holds the port for a burst of up to MAX_BURST
// cycles; gnt is one-hot and registered so it can drive the bank's load
// strobes directly. The priority pointer moves past each holder on release.
//
// Optional feature macro: RR_ARB_LOCK_EN
//   defined     : lock port present; a holder with lock=1 is exempt from the
//                 MAX_BURST limit (beat saturates at MAX_BURST)
//   not defined : no lock port; MAX_BURST always enforced
//
// Ports:
//   clock      in   1        rising-edge clock
//   reset      in   1        synchronous, active-high
//   req        in   N        level requests, held until granted
//   last       in   N        holder's final beat this cycle (holder bit only)
//   lock       in   N        extend tenure past MAX_BURST (RR_ARB_LOCK_EN only)
//   gnt        out  N        one-hot grant, registered
//   gnt_id     out  ID_W     holder index, meaningful while gnt_valid
//   gnt_valid  out  1        a grant is active
//   beat       out  BEAT_W   beats consumed in current tenure, incl. this one
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no holder; any request is granted at the next edge
// GRANT | gnt holds one requester; on release the next winner is
//       | granted in the same edge, or the FSM falls back to IDLE
// ----------------------------------------------------------------------------
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N-1:0]                   req,
    input  logic [N-1:0]                   last,
`ifdef RR_ARB_LOCK_EN
    input  logic [N-1:0]                   lock,
`endif
    output logic [N-1:0]                   gnt,
    output logic [$clog2(N)-1:0]           gnt_id,
    output logic                           gnt_valid,
    output logic [$clog2(MAX_BURST+1)-1:0] beat
);

    localparam int ID_W   = $clog2(N);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    arb_state_t      state;
    logic [ID_W-1:0] ptr;

    logic [ID_W-1:0] pick_ptr;
    logic [N-1:0]    pick;
    logic [ID_W-1:0] pick_id;
    logic            any;

    logic            hold_req;
    logic            hold_last;
    logic            hold_lock;
    logic            at_max;
    logic            release_now;
    logic [BEAT_W-1:0] beat_inc;

    // While granted, the pick is evaluated as if ptr had already advanced
    // past the holder, so the holder lands at the lowest priority. It only
    // wins again when nobody else is asking, which gives back-to-back
    // tenures to a lone requester without a bubble.
    assign pick_ptr = (state == GRANT) ? ID_W'(next_ptr(int'(gnt_id), N)) : ptr;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (any)
    );

    assign hold_req  = |(req & gnt);
    assign hold_last = |(last & gnt);
`ifdef RR_ARB_LOCK_EN
    assign hold_lock = |(lock & gnt);
`else
    assign hold_lock = 1'b0;
`endif

    assign at_max      = (beat == BEAT_MAX);
    // last and the burst limit together still make a single release
    assign release_now = hold_last | ~hold_req | (at_max & ~hold_lock);
    // saturate so a locked holder never wraps the beat counter
    assign beat_inc    = at_max ? beat : beat + BEAT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            beat      <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state     <= GRANT;
                        gnt       <= pick;
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        beat      <= BEAT_ONE;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= pick_ptr;
                        if (any) begin
                            gnt     <= pick;
                            gnt_id  <= pick_id;
                            beat    <= BEAT_ONE;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            beat      <= '0;
                        end
                    end else begin
                        beat <= beat_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    beat      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_burst_arbiter
// Directed bench for rr_burst_arbiter (N=4, MAX_BURST=8). Inputs change 1 time
// unit after the rising edge; outputs are examined at that same point, so
// each check sees the result of the edge that sampled the previous inputs.
// ----------------------------------------------------------------------------
module tb_rr_burst_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic [3:0] beat;

    int n_cmp = 0;
    int n_err = 0;

    rr_burst_arbiter #(
        .N         (4),
        .MAX_BURST (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .last      (last),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .beat      (beat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // gnt must never carry more than one set bit
    always @(negedge clock) begin
        n_cmp++;
        assert ($onehot0(gnt)) else begin
            n_err++;
            $error("FAIL onehot: observed gnt=%b expected at most one bit set", gnt);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] id_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk_state(input string tag, input logic [3:0] eg, input logic [3:0] eb);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|eg));
        chk({tag, ".beat"}, 32'(beat), 32'(eb));
        if (eg != 4'b0000)
            chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id_of(eg)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        last  = 4'b0000;
        lock  = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] eg;
    logic [3:0] eb;

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        last  = 4'b0000;
        lock  = 4'b0000;

        // 1: reset values, then idle with no requests
        tick();
        chk_state("t1_rst", 4'b0000, 4'd0);
        chk("t1_rst.gnt_id", 32'(gnt_id), 32'd0);
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk_state("t1_idle", 4'b0000, 4'd0);
        end

        // 2: all requesting, full 8-beat bursts, rotation with wrap 3->0
        req = 4'b1111;
        for (int t = 0; t < 33; t++) begin
            tick();
            eg = 4'b0001 << ((t / 8) % 4);
            eb = 4'((t % 8) + 1);
            chk_state("t2_rot", eg, eb);
        end

        // 3: two requesters, last on holder's 2nd beat; non-holder last ignored
        do_reset();
        req = 4'b0101;
        tick();
        chk_state("t3_a", 4'b0001, 4'd1);
        last = 4'b1110;
        tick();
        chk_state("t3_b", 4'b0001, 4'd2);
        last = 4'b0001;
        tick();
        chk_state("t3_c", 4'b0100, 4'd1);
        last = 4'b0000;
        tick();
        chk_state("t3_d", 4'b0100, 4'd2);
        last = 4'b0100;
        tick();
        chk_state("t3_e", 4'b0001, 4'd1);
        last = 4'b0000;

        // 4: reset mid-tenure with ptr moved away from 0
        do_reset();
        req = 4'b0010;
        tick();
        chk_state("t4_a", 4'b0010, 4'd1);
        req  = 4'b0110;
        last = 4'b0010;
        tick();
        chk_state("t4_b", 4'b0100, 4'd1);
        last = 4'b0000;
        tick();
        tick();
        chk_state("t4_c", 4'b0100, 4'd3);
        reset = 1'b1;
        tick();
        chk_state("t4_rst", 4'b0000, 4'd0);
        chk("t4_rst.gnt_id", 32'(gnt_id), 32'd0);
        reset = 1'b0;
        tick();
        chk_state("t4_after", 4'b0010, 4'd1);

        // last together with beat==MAX_BURST: one release only
        do_reset();
        req = 4'b0011;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk_state("t_maxlast", 4'b0001, 4'((t + 1)));
        end
        last = 4'b0001;
        tick();
        chk_state("t_maxlast_rel", 4'b0010, 4'd1);
        last = 4'b0000;
        tick();
        chk_state("t_maxlast_next", 4'b0010, 4'd2);

`ifdef RR_ARB_LOCK_EN
        // 5: lock holds the grant past MAX_BURST, beat saturates
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        tick();
        chk_state("t5_lock", 4'b0001, 4'd1);
        for (int t = 2; t <= 12; t++) begin
            tick();
            chk_state("t5_lock", 4'b0001, (t > 8) ? 4'd8 : 4'(t));
        end
        lock = 4'b0000;
        tick();
        chk_state("t5_drop", 4'b0010, 4'd1);
`endif

        // 6: lone requester, last every 3rd beat, no gap between tenures
        do_reset();
        req = 4'b1000;
        tick();
        chk_state("t6_a", 4'b1000, 4'd1);
        for (int i = 1; i <= 8; i++) begin
            last = (((i - 1) % 3) + 1 == 3) ? 4'b1000 : 4'b0000;
            tick();
            chk_state("t6_seq", 4'b1000, 4'((i % 3) + 1));
        end
        last = 4'b0000;
        req  = 4'b0000;
        tick();
        chk_state("t6_idle", 4'b0000, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
